// File: rtl/gate_truth_table_checker_if.sv
// ---------------------------------------------------------------------------
// gate_truth_table_checker_if
//   Bundles the run-control, gate-drive and result signals of
//   gate_truth_table_checker so the checker and its host share one connection.
//
//   Signals
//     start      host -> checker  request a run (sampled only when idle)
//     gate_sel   host -> checker  expected gate function (latched at start)
//     dut_y      gate -> checker  output of the gate under test
//     dut_a      checker -> gate  gate input a (registered)
//     dut_b      checker -> gate  gate input b (registered)
//     busy       checker -> host  run in progress
//     done       checker -> host  one-cycle pulse when a run completes
//     pass       checker -> host  last run had no mismatches
//     err_count  checker -> host  number of mismatching vectors in last run
//     fail_vec   checker -> host  bit i set if vector i (a=i[1], b=i[0]) failed
//
//   Modports
//     master  host / environment side
//     slave   checker side
// ---------------------------------------------------------------------------
interface gate_truth_table_checker_if;
  logic       start;
  logic [2:0] gate_sel;
  logic       dut_y;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  modport master (
    output start, gate_sel, dut_y,
    input  dut_a, dut_b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, gate_sel, dut_y,
    output dut_a, dut_b, busy, done, pass, err_count, fail_vec
  );
endinterface : gate_truth_table_checker_if

// File: rtl/gate_truth_table_checker.sv
// ---------------------------------------------------------------------------
// gate_truth_table_checker
//   Self-test sequencer for a two-input, one-output gate. On start it walks
//   the gate inputs through 00, 01, 10, 11, holds each vector for
//   SETTLE_CYCLES clocks, samples the gate output on the last of them and
//   compares it with the selected reference function. Reports pass/fail, a
//   per-vector failure mask and a mismatch count.
//
//   Parameters
//     SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//     CNT_W          settle counter width, must hold SETTLE_CYCLES
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    gate_truth_table_checker_if.slave (run control, gate drive,
//            gate output and results)
//
//   gate_sel encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR,
//                      6 BUF_A (y=a), 7 NOT_A (y=~a)
//   dut_y is assumed synchronous to clk; no synchronizer is provided.
// ---------------------------------------------------------------------------
module gate_truth_table_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  gate_truth_table_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Reference behaviour of each selectable gate function.
  function automatic logic f_expected(input logic [2:0] sel,
                                      input logic       a,
                                      input logic       b);
    case (sel)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  state_t           r_state;
  logic [2:0]       r_sel;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [2:0]       r_err;
  logic [3:0]       r_fail;

  logic             w_mismatch;
  logic [1:0]       w_next_idx;

  // The vector index is the {a,b} pair currently driven, so the expected
  // value is computed from the index rather than from the output registers.
  assign w_mismatch = bus.dut_y ^ f_expected(r_sel, r_idx[1], r_idx[0]);
  assign w_next_idx = r_idx + 2'd1;

  // NOTE: every register, including the result fields, is cleared by the
  // asynchronous reset, and all state uses non-blocking assignments so each
  // branch below reads the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_a <= 1'b0;
          r_b <= 1'b0;
          if (bus.start) begin
            r_sel   <= bus.gate_sel;
            r_idx   <= '0;
            r_cnt   <= RELOAD;
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (r_cnt == '0) begin
            // Sample edge for the current vector.
            if (w_mismatch) begin
              r_fail[r_idx] <= 1'b1;
              r_err         <= r_err + 3'd1;
            end
            if (r_idx != 2'd3) begin
              r_idx <= w_next_idx;
              r_a   <= w_next_idx[1];
              r_b   <= w_next_idx[0];
              r_cnt <= RELOAD;
            end else begin
              // Final sample: pass must account for this vector too.
              r_pass  <= (r_err == '0) && !w_mismatch;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dut_a     = r_a;
  assign bus.dut_b     = r_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.fail_vec  = r_fail;

endmodule : gate_truth_table_checker
